// File: rtl/systolic_array_engine.sv
// N x N output-stationary int8 systolic matrix engine: C = A x B with runtime K.
// Operands enter unskewed through valid/ready; result rows leave through valid/ready.
module systolic_array_engine #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [K_W-1:0]             k_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N*DATA_W-1:0]        a_col,
  input  logic [N*DATA_W-1:0]        b_row,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N*ACC_W-1:0]         out_row,
  output logic [$clog2(N)-1:0]       out_row_idx,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(2*N) + 1;
  localparam int EXT_W = ACC_W - 2*DATA_W;

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DRAIN, DONE} state_t;

  state_t               state;
  logic [K_W-1:0]       k_reg;
  logic [K_W-1:0]       beat_cnt;
  logic [CNT_W-1:0]     flush_cnt;
  logic                 advance;

  logic signed [DATA_W-1:0]   a_src  [N];
  logic signed [DATA_W-1:0]   b_src  [N];
  logic signed [DATA_W-1:0]   a_skew [N][N-1];
  logic signed [DATA_W-1:0]   b_skew [N][N-1];
  logic signed [DATA_W-1:0]   a_pe   [N][N];
  logic signed [DATA_W-1:0]   b_pe   [N][N];
  logic signed [DATA_W-1:0]   a_in   [N][N];
  logic signed [DATA_W-1:0]   b_in   [N][N];
  logic signed [2*DATA_W-1:0] prod   [N][N];
  logic signed [ACC_W-1:0]    acc    [N][N];

  // FLUSH injects zeros; only LOAD presents caller operands to the skew chains.
  for (genvar gi = 0; gi < N; gi++) begin : g_src
    assign a_src[gi] = (state == LOAD) ? a_col[gi*DATA_W +: DATA_W] : '0;
    assign b_src[gi] = (state == LOAD) ? b_row[gi*DATA_W +: DATA_W] : '0;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      if (gj == 0) begin : g_aedge
        if (gi == 0) begin : g_adirect
          assign a_in[gi][gj] = a_src[gi];
        end else begin : g_askew
          assign a_in[gi][gj] = a_skew[gi][gi-1];
        end
      end else begin : g_afwd
        assign a_in[gi][gj] = a_pe[gi][gj-1];
      end
      if (gi == 0) begin : g_bedge
        if (gj == 0) begin : g_bdirect
          assign b_in[gi][gj] = b_src[gj];
        end else begin : g_bskew
          assign b_in[gi][gj] = b_skew[gj][gj-1];
        end
      end else begin : g_bfwd
        assign b_in[gi][gj] = b_pe[gi-1][gj];
      end
      assign prod[gi][gj] = a_in[gi][gj] * b_in[gi][gj];
    end
  end

  assign advance = ((state == LOAD) && in_valid && in_ready) ||
                   ((state == FLUSH) && (flush_cnt < CNT_W'(2*N-2)));

  // Array datapath plus job FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      k_reg       <= '0;
      beat_cnt    <= '0;
      flush_cnt   <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_row     <= '0;
      out_row_idx <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int s = 0; s < N-1; s++) begin
          a_skew[i][s] <= '0;
          b_skew[i][s] <= '0;
        end
        for (int j = 0; j < N; j++) begin
          a_pe[i][j] <= '0;
          b_pe[i][j] <= '0;
          acc[i][j]  <= '0;
        end
      end
    end else begin
      if (advance) begin
        for (int i = 0; i < N; i++) begin
          a_skew[i][0] <= a_src[i];
          b_skew[i][0] <= b_src[i];
          for (int s = 1; s < N-1; s++) begin
            a_skew[i][s] <= a_skew[i][s-1];
            b_skew[i][s] <= b_skew[i][s-1];
          end
          for (int j = 0; j < N; j++) begin
            a_pe[i][j] <= a_in[i][j];
            b_pe[i][j] <= b_in[i][j];
            acc[i][j]  <= acc[i][j] + {{EXT_W{prod[i][j][2*DATA_W-1]}}, prod[i][j]};
          end
        end
      end

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            k_reg       <= k_len;
            beat_cnt    <= '0;
            flush_cnt   <= '0;
            out_row     <= '0;
            out_row_idx <= '0;
            busy        <= 1'b1;
            for (int i = 0; i < N; i++) begin
              for (int s = 0; s < N-1; s++) begin
                a_skew[i][s] <= '0;
                b_skew[i][s] <= '0;
              end
              for (int j = 0; j < N; j++) begin
                a_pe[i][j] <= '0;
                b_pe[i][j] <= '0;
                acc[i][j]  <= '0;
              end
            end
            if (k_len != '0) begin
              state    <= LOAD;
              in_ready <= 1'b1;
            end else begin
              state     <= DRAIN;
              out_valid <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            beat_cnt <= beat_cnt + K_W'(1);
            if (beat_cnt == k_reg - K_W'(1)) begin
              in_ready  <= 1'b0;
              flush_cnt <= '0;
              state     <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // 2N-2 advancing cycles, then one cycle to register row 0 of the settled sums.
          flush_cnt <= flush_cnt + CNT_W'(1);
          if (flush_cnt == CNT_W'(2*N-2)) begin
            for (int j = 0; j < N; j++) out_row[j*ACC_W +: ACC_W] <= acc[0][j];
            out_row_idx <= '0;
            out_valid   <= 1'b1;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_row_idx == IDX_W'(N-1)) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              out_row_idx <= out_row_idx + IDX_W'(1);
              for (int j = 0; j < N; j++)
                out_row[j*ACC_W +: ACC_W] <= acc[out_row_idx + IDX_W'(1)][j];
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/systolic_array_engine.md
Name: systolic_array_engine

Overview:
Parametrised N x N output-stationary int8 systolic matrix engine that computes C = A x B for an N x K by K x N job, where K is chosen at runtime. It builds on our 2x2 PE array and adds:
- internal input skewing, so callers supply unskewed columns and rows;
- a job FSM with start/done control;
- valid/ready streaming of operands in and of result rows out.
It sits between the operand fetch logic and the result writeback buffer.

Parameters:
N, 4, array dimension (rows = columns = N); N >= 2
DATA_W, 8, signed operand width
ACC_W, 32, signed accumulator width
K_W, 8, width of k_len; maximum K = 2^K_W - 1

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous active-high reset
start  input  1  job request; sampled only in IDLE
k_len  input  K_W  inner dimension K; sampled together with start
in_valid  input  1  operand beat valid
in_ready  output  1  engine accepts an operand beat
a_col  input  N*DATA_W  slice i = A[i][k] for the current beat k
b_row  input  N*DATA_W  slice j = B[k][j] for the current beat k
out_valid  output  1  result row valid
out_ready  input  1  downstream accepts the result row
out_row  output  N*ACC_W  slice j = C[r][j]
out_row_idx  output  $clog2(N)  result row index r
busy  output  1  high in LOAD, FLUSH and DRAIN
done  output  1  one-cycle pulse at job completion

Behaviour:
- One clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values:
  - FSM returns to IDLE.
  - All accumulators, skew registers and PE pipeline registers clear to 0.
  - in_ready, out_valid, busy and done are 0; out_row and out_row_idx are 0.
- Reset asserted mid-job aborts the job immediately. No done pulse is produced, and the next start after reset runs a clean job.
- FSM states: IDLE, LOAD, FLUSH, DRAIN, DONE.
- IDLE:
  - start=1 latches k_len, clears all accumulators and all skew/PE data registers.
  - If k_len != 0, go to LOAD; if k_len = 0, go to DRAIN (result is all zeros).
  - start is ignored in every state other than IDLE.
- LOAD:
  - in_ready=1. A beat is accepted when in_valid and in_ready are both 1 in the same cycle.
  - Each accepted beat advances the array one step. Row i of A passes through i skew stages; column j of B passes through j skew stages.
  - Each PE does acc += a*b, then forwards a to the right and b downward.
  - No accepted beat means no advance: every register holds and no accumulation occurs.
  - After beat K-1 is accepted, go to FLUSH.
- FLUSH:
  - in_ready=0. The array advances every cycle with zero operands injected.
  - Runs for exactly 2N-2 cycles; a counter is required. Then go to DRAIN.
  - PE[i][j] sees the products for step k at array step k+i+j. The final product therefore lands in PE[N-1][N-1] on the last FLUSH cycle.
- DRAIN:
  - out_valid=1, out_row = row r of the accumulators, out_row_idx = r, with r starting at 0.
  - On an out_valid & out_ready handshake, r increments. The handshake at r = N-1 goes to DONE.
  - While out_ready=0, out_row and out_row_idx hold stable.
- DONE: done=1 for one cycle, busy=0, then IDLE. A new start is accepted in the cycle after DONE.
- Arithmetic:
  - Products are signed DATA_W x DATA_W giving 2*DATA_W bits, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W, with no saturation.
- Latency with no stalls and out_ready=1: start at cycle T; first beat accepted at T+1; out_valid first high at T+1+K+(2N-2)+1; done at T+K+2N+N.
- Outputs are registered; no combinational path from in_valid to in_ready or from out_ready to out_valid.

Test Plan:
1. N=4, K=4, A=identity, B[k][j]=10k+j, in_valid held high -> rows r=0..3 equal B row r (e.g. row 2 = 20,21,22,23); done pulses exactly once at cycle T+16.
2. K=255, all A=-128, all B=-128 -> every C element = 255*16384 = 4177920; second job with all A=127, all B=-128 -> -4145280.
3. Case 1 repeated with in_valid toggling 1,0,1,0 and random gaps -> results identical to case 1; in_ready never high outside LOAD.
4. out_ready held low for 5 cycles while r=1 -> out_row and out_row_idx=1 stable for those cycles; rows still arrive in order 0..3 with no duplicates.
5. k_len=0 -> in_ready never asserted; four all-zero rows drained; done pulses; start pulsed during DRAIN ignored.
6. reset asserted during FLUSH -> next cycle all outputs 0 and FSM in IDLE; no done pulse; next job with case-1 data produces correct results (no stale accumulation).
